// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } boot_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// Packs accepted payload bytes LSB-first into 32-bit words and pulses
// o_word_valid the cycle after the last byte of each word lands.
module word_assembler
  import boot_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_byte_en,
  input  logic [7:0]            i_byte,
  output logic [BYTE_CNT_W-1:0] o_byte_cnt,
  output logic                  o_word_valid,
  output logic [31:0]           o_word
);

  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [31:0]           r_word;
  logic                  r_word_valid;
  logic                  w_last_byte;

  assign w_last_byte = (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_byte_en && w_last_byte;
      if (i_byte_en) begin
        r_word[{r_byte_cnt, 3'b000} +: 8] <= i_byte;
        r_byte_cnt                        <= r_byte_cnt + 1'b1;
      end
    end
  end

  assign o_byte_cnt   = r_byte_cnt;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/instr_boot_loader.sv
// Framed byte-stream program loader: writes little-endian words into
// instruction memory and releases the CPU only after the XOR checksum matches.
module instr_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 256  // must not exceed 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  // Handshake: a byte moves on a rising edge when in_valid & in_ready;
  // in_ready is combinational and drops while reset is low or start is high.

  boot_state_e           r_state;
  logic [7:0]            r_len_lo;
  logic [ADDR_WIDTH:0]   r_num_words;
  logic [ADDR_WIDTH:0]   r_word_cnt;
  logic [7:0]            r_csum;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_data_byte;
  logic                  w_last_byte;
  logic [15:0]           w_len;
  logic [BYTE_CNT_W-1:0] w_byte_cnt;
  logic                  w_word_valid;
  logic [31:0]           w_word;

  assign in_ready    = reset && !start && (r_state != DONE) && (r_state != ERR);
  assign w_accept    = in_valid && in_ready;
  assign w_data_byte = w_accept && (r_state == DATA);
  assign w_last_byte = (w_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign w_len       = {in_data, r_len_lo};

  word_assembler u_word_assembler (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_clear      (start),
    .i_byte_en    (w_data_byte),
    .i_byte       (in_data),
    .o_byte_cnt   (w_byte_cnt),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LEN_LO;
      r_len_lo    <= '0;
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_csum      <= '0;
      r_imem_addr <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else if (start) begin
      r_state     <= LEN_LO;
      r_len_lo    <= '0;
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_csum      <= '0;
      r_imem_addr <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        LEN_LO: begin
          r_len_lo <= in_data;
          r_state  <= LEN_HI;
        end
        LEN_HI: begin
          if (w_len == 16'd0) begin
            r_state <= CHECK;
          end else if (32'(w_len) > MAX_WORDS) begin
            r_state <= ERR;
            r_error <= 1'b1;
          end else begin
            r_num_words <= w_len[ADDR_WIDTH:0];
            r_state     <= DATA;
          end
        end
        DATA: begin
          r_csum <= r_csum ^ in_data;
          // The address is latched here so it lines up with the
          // assembler's word_valid pulse one cycle later.
          if (w_last_byte) begin
            r_imem_addr <= r_word_cnt[ADDR_WIDTH-1:0];
            r_word_cnt  <= r_word_cnt + 1'b1;
            if (r_word_cnt == r_num_words - 1'b1) begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (in_data == r_csum) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end else begin
            r_state <= ERR;
            r_error <= 1'b1;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign imem_we    = w_word_valid;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = w_word;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_boot_loader.sv
// Directed and randomized frames for instr_boot_loader, checked against a
// word-level model of the frame format and checksum rule.
module tb_instr_boot_loader;

  localparam int ADDR_WIDTH = 8;
  localparam int MAX_WORDS  = 256;
  localparam int W          = ADDR_WIDTH + 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_reset;
  logic                  done;
  logic                  error;
  logic [2:0]            dbg_state;

  instr_boot_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_WORDS  (MAX_WORDS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int              n_cmp = 0;
  int              n_bad = 0;
  int              ready_viol = 0;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    got_q[$];
  logic [31:0]     words_q[$];
  logic [7:0]      frame_q[$];
  int              hdr_n;
  logic [7:0]      cs_flip;

  always @(negedge clk) begin
    if (imem_we) got_q.push_back({imem_addr, imem_wdata});
    if (done && in_ready) ready_viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change at negedge, handshakes resolve at posedge
  task automatic send_byte(input logic [7:0] b, input bit bubbles);
    bit acc = 1'b0;
    if (bubbles && $urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 32 && !acc; t++) begin
      #1;
      acc = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("byte_accept", 64'(acc), 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_cpu_reset", 64'(cpu_reset), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_error", 64'(error), 64'd0);
    check("start_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Reference model: build the frame from words_q/hdr_n/cs_flip, predict
  // the write list and the final verdict, then drive and compare.
  task automatic run_frame(input bit do_start, input bit bubbles);
    logic [7:0] cs;
    bit         exp_done;
    int         nb;
    if (do_start) pulse_start();
    got_q.delete();
    exp_q.delete();
    frame_q.delete();
    frame_q.push_back(8'(hdr_n));
    frame_q.push_back(8'(hdr_n >> 8));
    cs = 8'h00;
    if (hdr_n <= MAX_WORDS) begin
      for (int i = 0; i < hdr_n; i++) begin
        for (int k = 0; k < 4; k++) begin
          logic [7:0] b;
          b = 8'(words_q[i] >> (8 * k));
          cs ^= b;
          frame_q.push_back(b);
        end
        exp_q.push_back({8'(i), words_q[i]});
      end
      frame_q.push_back(cs ^ cs_flip);
    end
    exp_done = (hdr_n <= MAX_WORDS) && (cs_flip == 8'h00);
    nb = frame_q.size();
    for (int i = 0; i < nb; i++) begin
      if (i == nb - 1) check("done_early", 64'(done), 64'd0);
      send_byte(frame_q[i], bubbles);
    end
    check("done", 64'(done), 64'(exp_done));
    check("error", 64'(error), 64'(!exp_done));
    check("cpu_reset", 64'(cpu_reset), 64'(!exp_done));
    check("in_ready_final", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("write_entry", 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);

    // good 2-word frame, no bubbles (checksum 0x71)
    words_q = '{32'h00500093, 32'h00A00113};
    hdr_n   = 2;
    cs_flip = 8'h00;
    run_frame(1'b0, 1'b0);

    // same frame with checksum 0x72
    cs_flip = 8'h03;
    run_frame(1'b1, 1'b0);

    // length boundaries
    words_q.delete();
    hdr_n   = 0;
    cs_flip = 8'h00;
    run_frame(1'b1, 1'b0);
    cs_flip = 8'hFF;
    run_frame(1'b1, 1'b0);
    hdr_n   = 257;
    cs_flip = 8'h00;
    run_frame(1'b1, 1'b0);

    // 8-instruction program with bubbles
    words_q = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40110233,
                32'h0020F2B3, 32'h0020E333, 32'h00302023, 32'h00008067};
    hdr_n   = 8;
    run_frame(1'b1, 1'b1);

    // randomized frames
    for (int r = 0; r < 6; r++) begin
      words_q.delete();
      hdr_n = $urandom_range(1, 6);
      for (int i = 0; i < hdr_n; i++) words_q.push_back($urandom);
      cs_flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(1'b1, r[0]);
    end

    // reset mid-frame after 6 payload bytes
    pulse_start();
    frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_imem_we", 64'(imem_we), 64'd0);
    check("midrst_imem_addr", 64'(imem_addr), 64'd0);
    check("midrst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_error", 64'(error), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // start abort after 3 payload bytes, colliding with a valid byte
    frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50};
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h01;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_cpu_reset", 64'(cpu_reset), 64'd1);
    @(negedge clk);
    words_q = '{32'h00500093};
    hdr_n   = 1;
    cs_flip = 8'h00;
    run_frame(1'b0, 1'b0);

    // reload after DONE
    words_q = '{32'hDEADBEEF, 32'h12345678, 32'h00000013};
    hdr_n   = 3;
    run_frame(1'b1, 1'b1);

    check("ready_in_done", 64'(ready_viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_boot_loader.md
Name: instr_boot_loader

Overview:
- Byte-stream program loader; the writer side of the instruction memory that the fetch stage reads.
- Receives a framed program over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes each word into instruction memory, holding the CPU in reset until the checksum passes; after a good frame, releases the CPU to execute from word 0.
- Replaces hierarchical memory preloading, so programs can be loaded in both simulation and hardware.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted word count; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; reset=0 forces all state to reset values immediately.
- start  in  1  single-cycle pulse; aborts any frame in progress and rearms the loader.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a byte transfers when in_valid & in_ready at a rising edge.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  write data.
- cpu_reset  out  1  active-high reset to the CPU.
- done  out  1  frame loaded and verified.
- error  out  1  frame rejected.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word's LSB first), then 1 checksum byte.
- Checksum: XOR of all payload bytes; header bytes are not included.
- Reset values:
  - State LEN_LO; word counter, byte counter and checksum accumulator 0.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - in_ready=0, gated combinationally by reset.
- in_ready: 1 in LEN_LO, LEN_HI, DATA and CHECK, but only when reset=1 and start=0; 0 in DONE and ERR.
- State transitions (one per accepted byte unless noted):
  - LEN_LO -> LEN_HI.
  - LEN_HI -> CHECK if N=0.
  - LEN_HI -> ERR if N>MAX_WORDS, with no payload consumed.
  - LEN_HI -> DATA otherwise.
  - DATA: byte counter 0..3 shifts in_data into bits [8k+7:8k] of the word register; XOR each byte into the accumulator.
  - DATA, 4th byte: in the next cycle imem_we=1 for exactly one cycle, imem_addr=word counter, imem_wdata=assembled word.
  - DATA, 4th byte: word counter increments; after word N-1 go to CHECK.
  - CHECK: byte equal to accumulator -> DONE; otherwise -> ERR.
- Write latency: 1 cycle from the 4th byte handshake to the imem_we pulse. Back-to-back bytes give at most one write per 4 cycles, so strobes never overlap.
- DONE: cpu_reset=0 and done=1, registered and asserted the cycle after the checksum handshake. Held until start or reset.
- ERR: cpu_reset=1 and error=1, held until start or reset.
- Memory contents after ERR: words already written stay in memory; no rollback.
- start (any state):
  - Next state LEN_LO; counters and accumulator cleared.
  - cpu_reset=1, done=0, error=0.
  - Any pending imem_we is cancelled.
- start coinciding with in_valid: in_ready is 0 that cycle, so the byte is not consumed.
- Bubbles: in_valid low stalls any state indefinitely, with no timeout.
- Word counter width: ADDR_WIDTH+1 bits so that N=MAX_WORDS=2**ADDR_WIDTH is representable. imem_addr uses the low ADDR_WIDTH bits.
- reset asserted mid-frame: immediate return to reset values and the partial word is discarded. The CPU is held in reset (cpu_reset=1).

Decomposition:
- Package boot_pkg holds:
  - State enum: LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
  - HDR_BYTES=2 and BYTES_PER_WORD=4.
- One sub-module, word_assembler:
  - Byte counter, shift-in word register and word_valid pulse.
  - Cleared by start or reset.
  - The top level keeps the FSM, word counter, checksum and outputs.

Test Plan:
- Good 2-word frame, stream 02 00 93 00 50 00 13 01 A0 00 71, no bubbles:
  - imem_we pulses with (addr 0, 00500093) then (addr 1, 00A00113).
  - done=1 and cpu_reset=0 one cycle after byte 0x71.
  - error=0.
- Same frame with checksum 0x72 -> error=1, cpu_reset stays 1, done=0. Both words were still written.
- Length boundaries:
  - 00 00 00 -> DONE with no imem_we.
  - 00 00 FF -> ERR.
  - N=257 (01 01) with MAX_WORDS=256 -> ERR right after LEN_HI, in_ready=0.
- Random in_valid bubbles (≈50%) during the 8-instruction program 00500093 … 00008067:
  - Identical write sequence at addresses 0..7, DONE.
  - in_ready never high in DONE.
- Mid-frame aborts:
  - reset=0 after 6 payload bytes -> all outputs at reset values immediately.
  - start pulse with in_valid=1 after 3 payload bytes -> byte not consumed. Then a fresh 1-word frame 01 00 93 00 50 00 C3 writes addr 0=00500093 and reaches DONE.
- Reload: after DONE, start -> cpu_reset=1, done=0 the next cycle. A second frame loads and verifies.
